// File: rtl/led_display_panel_rx.sv
// Panel-side receiver for a HUB75-style interface: synchronises the panel
// inputs, deserialises each shifted line and, on latch, streams one pixel
// word per column over a valid/ready handshake with error pulses.
module led_display_panel_rx #(
  parameter int NUM_ROW_PIXELS = 32,
  parameter int NUM_COL_PIXELS = 64,
  parameter int ROW_ADDR_W     = $clog2(NUM_ROW_PIXELS / 2),
  parameter int COL_W          = $clog2(NUM_COL_PIXELS),
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  clk_in,
  input  logic                  n_reset_in,
  input  logic                  panel_bclk_in,
  input  logic                  panel_latch_in,
  input  logic                  panel_oe_n_in,
  input  logic [ROW_ADDR_W-1:0] panel_addr_in,
  input  logic [2:0]            panel_rgb_top_in,
  input  logic [2:0]            panel_rgb_bot_in,
  output logic                  pix_valid_out,
  input  logic                  pix_ready_in,
  output logic [COL_W-1:0]      pix_col_out,
  output logic [ROW_ADDR_W-1:0] pix_row_out,
  output logic [2:0]            pix_rgb_top_out,
  output logic [2:0]            pix_rgb_bot_out,
  output logic                  line_done_out,
  output logic                  len_err_out,
  output logic                  ovr_err_out,
  output logic                  oe_err_out,
  output logic [15:0]           lines_ok_out
);

  localparam int               CNT_W    = $clog2(NUM_COL_PIXELS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_COL_PIXELS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NUM_COL_PIXELS + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COL_PIXELS - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } stateT;

  logic [SYNC_STAGES-1:0]                 bclkSync_q;
  logic [SYNC_STAGES-1:0]                 latchSync_q;
  logic [SYNC_STAGES-1:0]                 oeNSync_q;
  logic [SYNC_STAGES-1:0][ROW_ADDR_W-1:0] addrSync_q;
  logic [SYNC_STAGES-1:0][5:0]            rgbSync_q;
  logic                                   bclkDly_q;
  logic                                   latchDly_q;

  logic                  bclkEvt_q;
  logic                  latchEvt_q;
  logic                  oeNEvt_q;
  logic [ROW_ADDR_W-1:0] addrEvt_q;
  logic [5:0]            rgbEvt_q;

  logic [NUM_COL_PIXELS-1:0][5:0] shiftBuf_q;
  logic [NUM_COL_PIXELS-1:0][5:0] shiftBuf_d;
  logic [NUM_COL_PIXELS-1:0][5:0] lineBuf_q;
  logic [CNT_W-1:0]               bitCnt_q;
  logic [CNT_W-1:0]               bitCnt_d;
  logic [CNT_W-1:0]               cntInc;
  logic [CNT_W-1:0]               cntSeen;
  logic [ROW_ADDR_W-1:0]          row_q;
  logic [15:0]                    linesOk_q;
  logic                           lenErr_q;
  logic                           lenErr_d;
  logic                           ovrErr_q;
  logic                           ovrErr_d;
  logic                           oeErr_q;
  logic                           oeErr_d;
  logic                           acceptLine;

  stateT            state_q;
  stateT            state_d;
  logic [COL_W-1:0] col_q;
  logic [COL_W-1:0] col_d;
  logic             pixValid;
  logic             lineDone;
  logic [5:0]       pixWord;

  // Synchronise every panel input, keep a delayed copy for edge detection,
  // and register the detected edges together with the data that goes with them.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      bclkSync_q  <= '0;
      latchSync_q <= '0;
      oeNSync_q   <= '1;
      addrSync_q  <= '0;
      rgbSync_q   <= '0;
      bclkDly_q   <= 1'b0;
      latchDly_q  <= 1'b0;
      bclkEvt_q   <= 1'b0;
      latchEvt_q  <= 1'b0;
      oeNEvt_q    <= 1'b1;
      addrEvt_q   <= '0;
      rgbEvt_q    <= '0;
    end else begin
      bclkSync_q  <= {bclkSync_q[SYNC_STAGES-2:0], panel_bclk_in};
      latchSync_q <= {latchSync_q[SYNC_STAGES-2:0], panel_latch_in};
      oeNSync_q   <= {oeNSync_q[SYNC_STAGES-2:0], panel_oe_n_in};
      addrSync_q  <= {addrSync_q[SYNC_STAGES-2:0], panel_addr_in};
      rgbSync_q   <= {rgbSync_q[SYNC_STAGES-2:0], {panel_rgb_top_in, panel_rgb_bot_in}};
      bclkDly_q   <= bclkSync_q[SYNC_STAGES-1];
      latchDly_q  <= latchSync_q[SYNC_STAGES-1];
      bclkEvt_q   <= bclkSync_q[SYNC_STAGES-1] & ~bclkDly_q;
      latchEvt_q  <= latchSync_q[SYNC_STAGES-1] & ~latchDly_q;
      oeNEvt_q    <= oeNSync_q[SYNC_STAGES-1];
      addrEvt_q   <= addrSync_q[SYNC_STAGES-1];
      rgbEvt_q    <= rgbSync_q[SYNC_STAGES-1];
    end
  end

  // Shift and count first, then judge a coincident latch against the updated count.
  always_comb begin
    cntInc     = (bitCnt_q == CNT_SAT) ? bitCnt_q : bitCnt_q + CNT_W'(1);
    cntSeen    = bclkEvt_q ? cntInc : bitCnt_q;
    shiftBuf_d = shiftBuf_q;
    if (bclkEvt_q) begin
      shiftBuf_d = {shiftBuf_q[NUM_COL_PIXELS-2:0], rgbEvt_q};
    end
    bitCnt_d   = cntSeen;
    lenErr_d   = 1'b0;
    ovrErr_d   = 1'b0;
    oeErr_d    = 1'b0;
    acceptLine = 1'b0;
    if (latchEvt_q) begin
      bitCnt_d = bclkEvt_q ? CNT_W'(1) : '0;
      oeErr_d  = ~oeNEvt_q;
      if (cntSeen != CNT_FULL) begin
        lenErr_d = 1'b1;
      end else if (state_q == STREAM) begin
        ovrErr_d = 1'b1;
      end else begin
        acceptLine = 1'b1;
      end
    end
  end

  // Capture registers: shift buffer, bit count, accepted line, row, counters and error pulses.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      shiftBuf_q <= '0;
      lineBuf_q  <= '0;
      bitCnt_q   <= '0;
      row_q      <= '0;
      linesOk_q  <= '0;
      lenErr_q   <= 1'b0;
      ovrErr_q   <= 1'b0;
      oeErr_q    <= 1'b0;
    end else begin
      shiftBuf_q <= shiftBuf_d;
      bitCnt_q   <= bitCnt_d;
      lenErr_q   <= lenErr_d;
      ovrErr_q   <= ovrErr_d;
      oeErr_q    <= oeErr_d;
      if (acceptLine) begin
        lineBuf_q <= shiftBuf_d;
        row_q     <= addrEvt_q;
        linesOk_q <= linesOk_q + 16'd1;
      end
    end
  end

  // Streaming FSM state and column registers.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state_q <= IDLE;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
    end
  end

  // Streaming FSM next state: one word per accepted handshake, last column ends the line.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    pixValid = 1'b0;
    lineDone = 1'b0;
    case (state_q)
      IDLE: begin
        if (acceptLine) begin
          state_d = STREAM;
          col_d   = '0;
        end
      end
      STREAM: begin
        pixValid = 1'b1;
        if (pix_ready_in) begin
          if (col_q == COL_LAST) begin
            lineDone = 1'b1;
            state_d  = IDLE;
            col_d    = '0;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Present the current word only while valid so an idle port reads as all zeros.
  always_comb begin
    pixWord         = lineBuf_q[col_q];
    pix_valid_out   = pixValid;
    pix_col_out     = pixValid ? col_q : '0;
    pix_row_out     = pixValid ? row_q : '0;
    pix_rgb_top_out = pixValid ? pixWord[5:3] : 3'b0;
    pix_rgb_bot_out = pixValid ? pixWord[2:0] : 3'b0;
    line_done_out   = lineDone;
    len_err_out     = lenErr_q;
    ovr_err_out     = ovrErr_q;
    oe_err_out      = oeErr_q;
    lines_ok_out    = linesOk_q;
  end

endmodule

// File: tb/tb_led_display_panel_rx.sv
// Self-checking bench for led_display_panel_rx: drives panel lines, predicts
// pixel words and error pulses from a line-level model, compares in a monitor.
module tb_led_display_panel_rx;

  logic        clk_in = 1'b0;
  logic        n_reset_in;
  logic        panel_bclk_in;
  logic        panel_latch_in;
  logic        panel_oe_n_in;
  logic [3:0]  panel_addr_in;
  logic [2:0]  panel_rgb_top_in;
  logic [2:0]  panel_rgb_bot_in;
  logic        pix_valid_out;
  logic        pix_ready_in;
  logic [5:0]  pix_col_out;
  logic [3:0]  pix_row_out;
  logic [2:0]  pix_rgb_top_out;
  logic [2:0]  pix_rgb_bot_out;
  logic        line_done_out;
  logic        len_err_out;
  logic        ovr_err_out;
  logic        oe_err_out;
  logic [15:0] lines_ok_out;

  int checks = 0;
  int errors = 0;

  logic [16:0] expQ[$];
  logic [5:0]  hist[$];
  int modelCnt   = 0;
  int lenExp     = 0;
  int ovrExp     = 0;
  int oeExp      = 0;
  int linesOkExp = 0;
  int doneExp    = 0;

  int lenObs     = 0;
  int ovrObs     = 0;
  int oeObs      = 0;
  int doneObs    = 0;
  int wordsSeen  = 0;
  int spurious   = 0;
  int readyMode  = 0;

  always #5 clk_in = ~clk_in;

  led_display_panel_rx dut (
    .clk_in           (clk_in),
    .n_reset_in       (n_reset_in),
    .panel_bclk_in    (panel_bclk_in),
    .panel_latch_in   (panel_latch_in),
    .panel_oe_n_in    (panel_oe_n_in),
    .panel_addr_in    (panel_addr_in),
    .panel_rgb_top_in (panel_rgb_top_in),
    .panel_rgb_bot_in (panel_rgb_bot_in),
    .pix_valid_out    (pix_valid_out),
    .pix_ready_in     (pix_ready_in),
    .pix_col_out      (pix_col_out),
    .pix_row_out      (pix_row_out),
    .pix_rgb_top_out  (pix_rgb_top_out),
    .pix_rgb_bot_out  (pix_rgb_bot_out),
    .line_done_out    (line_done_out),
    .len_err_out      (len_err_out),
    .ovr_err_out      (ovr_err_out),
    .oe_err_out       (oe_err_out),
    .lines_ok_out     (lines_ok_out)
  );

  // Compare one observed value against the expected one and report a mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: one more bit has been shifted into the panel line.
  task automatic shiftModel(input logic [2:0] top, input logic [2:0] bot);
    hist.push_back({top, bot});
    if (hist.size() > 64) void'(hist.pop_front());
    if (modelCnt < 65) modelCnt++;
  endtask

  // Model: a latch edge judged against the line as the panel sees it.
  task automatic latchModel(input logic [3:0] addr, input logic oeN);
    int idx;
    logic [5:0] px;
    if (!oeN) oeExp++;
    if (modelCnt != 64) begin
      lenExp++;
    end else if (expQ.size() != 0) begin
      ovrExp++;
    end else begin
      linesOkExp++;
      doneExp++;
      for (int c = 0; c < 64; c++) begin
        idx = hist.size() - 1 - c;
        px  = (idx >= 0) ? hist[idx] : 6'd0;
        expQ.push_back({addr, 6'(c), px, (c == 63)});
      end
    end
    modelCnt = 0;
  endtask

  // Drive one bit: data set while bclk low, then a rising edge held for two cycles.
  task automatic applyStimulus(input logic [2:0] top, input logic [2:0] bot);
    @(negedge clk_in);
    panel_rgb_top_in = top;
    panel_rgb_bot_in = bot;
    panel_bclk_in    = 1'b0;
    repeat (2) @(negedge clk_in);
    panel_bclk_in = 1'b1;
    shiftModel(top, bot);
    repeat (2) @(negedge clk_in);
    panel_bclk_in = 1'b0;
  endtask

  // Latch a line, optionally with a bclk rising edge in the very same cycle.
  task automatic latchLine(input logic [3:0] addr, input logic oeN, input bit withBit,
                           input logic [2:0] top, input logic [2:0] bot);
    @(negedge clk_in);
    panel_addr_in = addr;
    panel_oe_n_in = oeN;
    if (withBit) begin
      panel_rgb_top_in = top;
      panel_rgb_bot_in = bot;
      panel_bclk_in    = 1'b0;
    end
    repeat (2) @(negedge clk_in);
    panel_latch_in = 1'b1;
    if (withBit) begin
      panel_bclk_in = 1'b1;
      shiftModel(top, bot);
    end
    latchModel(addr, oeN);
    if (withBit) modelCnt = 1;
    repeat (3) @(negedge clk_in);
    panel_latch_in = 1'b0;
    panel_bclk_in  = 1'b0;
    panel_oe_n_in  = 1'b1;
    repeat (6) @(negedge clk_in);
  endtask

  task automatic shiftRandom(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
  endtask

  // Bounded wait for all predicted words to be consumed and the port to go idle.
  task automatic waitDrain(input int limit);
    int n;
    n = 0;
    while ((expQ.size() != 0 || pix_valid_out) && n < limit) begin
      @(negedge clk_in);
      n++;
    end
    #2;
    checkOutput("drain", 64'(expQ.size()), 64'd0);
    checkOutput("idle valid", 64'(pix_valid_out), 64'd0);
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, " len_err pulses"}, 64'(lenObs), 64'(lenExp));
    checkOutput({tag, " ovr_err pulses"}, 64'(ovrObs), 64'(ovrExp));
    checkOutput({tag, " oe_err pulses"}, 64'(oeObs), 64'(oeExp));
    checkOutput({tag, " line_done pulses"}, 64'(doneObs), 64'(doneExp));
    checkOutput({tag, " spurious words"}, 64'(spurious), 64'd0);
    checkOutput({tag, " lines_ok"}, 64'(lines_ok_out), 64'(linesOkExp & 32'hFFFF));
  endtask

  // Consumer and monitor: drive ready, then record transfers and pulses mid-cycle.
  initial begin
    logic [16:0] obs;
    logic [16:0] exp;
    forever begin
      @(negedge clk_in);
      case (readyMode)
        0:       pix_ready_in = 1'b1;
        1:       pix_ready_in = 1'b0;
        default: pix_ready_in = ($urandom_range(0, 99) >= 30);
      endcase
      #1;
      if (len_err_out)   lenObs++;
      if (ovr_err_out)   ovrObs++;
      if (oe_err_out)    oeObs++;
      if (line_done_out) doneObs++;
      if (pix_valid_out && pix_ready_in) begin
        wordsSeen++;
        obs = {pix_row_out, pix_col_out, pix_rgb_top_out, pix_rgb_bot_out, line_done_out};
        if (expQ.size() == 0) begin
          spurious++;
        end else begin
          exp = expQ.pop_front();
          checkOutput("pixel word", 64'(obs), 64'(exp));
        end
      end
    end
  end

  initial begin
    int base;
    int n;
    n_reset_in       = 1'b0;
    panel_bclk_in    = 1'b0;
    panel_latch_in   = 1'b0;
    panel_oe_n_in    = 1'b1;
    panel_addr_in    = 4'd0;
    panel_rgb_top_in = 3'd0;
    panel_rgb_bot_in = 3'd0;

    // Reset and idle
    repeat (5) @(negedge clk_in);
    #1;
    checkOutput("outputs in reset",
                64'({pix_valid_out, pix_col_out, pix_row_out, pix_rgb_top_out, pix_rgb_bot_out,
                     line_done_out, len_err_out, ovr_err_out, oe_err_out, lines_ok_out}), 64'd0);
    @(negedge clk_in);
    n_reset_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge clk_in);
      #1;
      checkOutput("idle outputs",
                  64'({pix_valid_out, pix_col_out, pix_row_out, pix_rgb_top_out, pix_rgb_bot_out,
                       line_done_out, len_err_out, ovr_err_out, oe_err_out, lines_ok_out}), 64'd0);
    end

    // One known line, column pattern, row 5
    readyMode = 0;
    for (int c = 63; c >= 0; c--) begin
      applyStimulus(3'(c % 8), ~3'(c % 8));
    end
    latchLine(4'd5, 1'b1, 1'b0, 3'd0, 3'd0);
    waitDrain(400);
    checkCounters("known line");

    // Short and long lines
    shiftRandom(63);
    latchLine(4'd2, 1'b1, 1'b0, 3'd0, 3'd0);
    shiftRandom(65);
    latchLine(4'd2, 1'b1, 1'b0, 3'd0, 3'd0);
    waitDrain(100);
    checkCounters("length errors");

    // Overrun while the consumer stalls
    readyMode = 1;
    shiftRandom(64);
    latchLine(4'd3, 1'b1, 1'b0, 3'd0, 3'd0);
    shiftRandom(64);
    latchLine(4'd9, 1'b1, 1'b0, 3'd0, 3'd0);
    readyMode = 0;
    waitDrain(400);
    checkCounters("overrun");

    // Random lines under backpressure, one OE-low latch, one coincident bclk/latch
    readyMode = 2;
    for (int k = 0; k < 20; k++) begin
      logic [3:0] addr;
      addr = (k < 16) ? 4'(k) : 4'($urandom_range(0, 15));
      if (k == 7) begin
        shiftRandom(64 - modelCnt - 1);
        waitDrain(1000);
        latchLine(addr, 1'b1, 1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end else begin
        shiftRandom(64 - modelCnt);
        waitDrain(1000);
        latchLine(addr, (k == 3) ? 1'b0 : 1'b1, 1'b0, 3'd0, 3'd0);
      end
    end
    waitDrain(1000);
    checkCounters("random lines");

    // Reset in the middle of a stream
    readyMode = 0;
    shiftRandom(64);
    base = wordsSeen;
    latchLine(4'd11, 1'b1, 1'b0, 3'd0, 3'd0);
    n = 0;
    while (wordsSeen < base + 30 && n < 500) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput("stream reached word 30", 64'(wordsSeen >= base + 30), 64'd1);
    @(negedge clk_in);
    n_reset_in = 1'b0;
    #2;
    checkOutput("valid after reset", 64'(pix_valid_out), 64'd0);
    checkOutput("line_done after reset", 64'(line_done_out), 64'd0);
    expQ.delete();
    hist.delete();
    modelCnt   = 0;
    linesOkExp = 0;
    doneExp--;
    repeat (3) @(negedge clk_in);
    n_reset_in = 1'b1;
    shiftRandom(64);
    latchLine(4'd6, 1'b1, 1'b0, 3'd0, 3'd0);
    waitDrain(400);
    checkCounters("after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
